// File: rtl/pos_pkg.sv
// Shared definitions for the position route scheduler: walker state codes,
// position codes, route decision bit indices, controller states, and the
// walker transition / position decode helpers.
package pos_pkg;

    // Walker state encoding
    localparam logic [3:0] S0  = 4'd0;
    localparam logic [3:0] S1  = 4'd1;
    localparam logic [3:0] S2  = 4'd2;
    localparam logic [3:0] S3  = 4'd3;
    localparam logic [3:0] S4  = 4'd4;
    localparam logic [3:0] S5  = 4'd5;
    localparam logic [3:0] S6  = 4'd6;
    localparam logic [3:0] S7  = 4'd7;
    localparam logic [3:0] S8  = 4'd8;
    localparam logic [3:0] S9  = 4'd9;
    localparam logic [3:0] S10 = 4'd10;
    localparam logic [3:0] S11 = 4'd11;
    localparam logic [3:0] S12 = 4'd12;
    localparam logic [3:0] S13 = 4'd13;
    localparam logic [3:0] S14 = 4'd14;
    localparam logic [3:0] S15 = 4'd15;

    // Position codes driven to the actuator
    localparam logic [1:0] POS_00 = 2'b00;
    localparam logic [1:0] POS_01 = 2'b01;
    localparam logic [1:0] POS_10 = 2'b10;
    localparam logic [1:0] POS_11 = 2'b11;

    // Route word decision bit indices (a is the MSB, g the LSB)
    localparam int RB_A = 6;
    localparam int RB_B = 5;
    localparam int RB_C = 4;
    localparam int RB_D = 3;
    localparam int RB_E = 2;
    localparam int RB_F = 1;
    localparam int RB_G = 0;

    // Controller states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    // Walker transition taken on a step, steered by the route decision bits
    function automatic logic [3:0] walker_next(input logic [3:0] st, input logic [6:0] route);
        logic [3:0] nxt;
        case (st)
            S0:            nxt = S1;
            S1:            nxt = route[RB_A] ? S2 : S3;
            S2, S3:        nxt = route[RB_B] ? S4 : S5;
            S4, S5:        nxt = S6;
            S6:            nxt = route[RB_C] ? S8 : S7;
            S7, S8:        nxt = route[RB_D] ? S9 : S10;
            S9, S10:       nxt = route[RB_E] ? S11 : (route[RB_F] ? S12 : S13);
            S11, S12, S13: nxt = S14;
            S14:           nxt = route[RB_G] ? S15 : S0;
            S15:           nxt = S0;
            default:       nxt = S0;
        endcase
        return nxt;
    endfunction

    // Actuator position for a given walker state
    function automatic logic [1:0] pos_decode(input logic [3:0] st);
        logic [1:0] p;
        case (st)
            S0, S1, S6, S7, S14: p = POS_00;
            S10:                 p = POS_11;
            S12:                 p = POS_10;
            default:             p = POS_01;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/pos_walker.sv
// Position walker: 16-state route-steered sequencer. Advances only on step,
// returns home on abort_clr, and presents the decoded actuator position.
// pos is registered together with the state, so it always equals the
// decode of the current state.
module pos_walker
    import pos_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic [6:0] route,
    input  logic       abort_clr,
    output logic [3:0] state,
    output logic [1:0] pos
);

    logic [3:0] state_r;
    logic [1:0] pos_r;
    logic [3:0] next_state_s;

    // Next walker state from the current state and latched route bits
    always_comb begin
        next_state_s = walker_next(state_r, route);
    end

    // Walker state and position register: abort homes it, step advances it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S0;
            pos_r   <= POS_00;
        end else if (abort_clr) begin
            state_r <= S0;
            pos_r   <= POS_00;
        end else if (step) begin
            state_r <= next_state_s;
            pos_r   <= pos_decode(next_state_s);
        end else begin
            state_r <= state_r;
            pos_r   <= pos_r;
        end
    end

    assign state = state_r;
    assign pos   = pos_r;

endmodule

// File: rtl/pos_route_sched.sv
// Position route scheduler: round-robin arbitration between two requesters,
// route/dwell latching, dwell pacing of the walker and pass completion.
// Optional feature: define POS_SCHED_ABORT_EN to add the abort/abort_ack
// ports, which cut a running pass short and home the walker.
module pos_route_sched
    import pos_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [6:0]         route0,
    input  logic [6:0]         route1,
    input  logic [DWELL_W-1:0] dwell,
`ifdef POS_SCHED_ABORT_EN
    input  logic               abort,
    output logic               abort_ack,
`endif
    output logic [1:0]         gnt,
    output logic               owner,
    output logic               busy,
    output logic               done,
    output logic               step,
    output logic [3:0]         walk_state,
    output logic [1:0]         pos
);

    ctrl_state_t        ctrl_r;
    logic [6:0]         route_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] cnt_r;
    logic               ptr_r;
    logic [1:0]         gnt_r;
    logic               owner_r;
    logic               busy_r;
    logic               done_r;
    logic               step_r;
`ifdef POS_SCHED_ABORT_EN
    logic               abort_ack_r;
`endif

    logic               win_valid_s;
    logic               win_idx_s;
    logic               last_step_s;
    logic               abort_run_s;
    logic [DWELL_W-1:0] cnt_inc_s;
    logic [3:0]         walk_state_s;

    // Arbitration: a lone requester wins, contention goes to the pointer's favourite
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = 1'b0;
        case (req)
            2'b01: begin
                win_valid_s = 1'b1;
                win_idx_s   = 1'b0;
            end
            2'b10: begin
                win_valid_s = 1'b1;
                win_idx_s   = 1'b1;
            end
            2'b11: begin
                win_valid_s = 1'b1;
                win_idx_s   = ptr_r;
            end
            default: begin
                win_valid_s = 1'b0;
                win_idx_s   = 1'b0;
            end
        endcase
    end

    // Pass-end detection and counter increment for the pacing logic
    always_comb begin
        last_step_s = step_r && (walker_next(walk_state_s, route_r) == S0);
        cnt_inc_s   = cnt_r + {{(DWELL_W-1){1'b0}}, 1'b1};
`ifdef POS_SCHED_ABORT_EN
        abort_run_s = abort && (ctrl_r == RUN);
`else
        abort_run_s = 1'b0;
`endif
    end

    // Controller FSM: grant and latch in IDLE, pace the walker in RUN.
    // step_r is precomputed so it is high exactly in cycles where the
    // running count equals the latched dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r      <= IDLE;
            route_r     <= 7'b0000000;
            dwell_r     <= {DWELL_W{1'b0}};
            cnt_r       <= {DWELL_W{1'b0}};
            ptr_r       <= 1'b0;
            gnt_r       <= 2'b00;
            owner_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            step_r      <= 1'b0;
`ifdef POS_SCHED_ABORT_EN
            abort_ack_r <= 1'b0;
`endif
        end else begin
            gnt_r       <= 2'b00;
            done_r      <= 1'b0;
`ifdef POS_SCHED_ABORT_EN
            abort_ack_r <= 1'b0;
`endif
            case (ctrl_r)
                IDLE: begin
                    if (win_valid_s) begin
                        ctrl_r  <= RUN;
                        busy_r  <= 1'b1;
                        gnt_r   <= win_idx_s ? 2'b10 : 2'b01;
                        owner_r <= win_idx_s;
                        route_r <= win_idx_s ? route1 : route0;
                        dwell_r <= dwell;
                        cnt_r   <= {DWELL_W{1'b0}};
                        step_r  <= (dwell == {DWELL_W{1'b0}});
                        if (req == 2'b11) begin
                            ptr_r <= ~win_idx_s;
                        end else begin
                            ptr_r <= ptr_r;
                        end
                    end else begin
                        busy_r <= 1'b0;
                        step_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort_run_s) begin
                        ctrl_r      <= IDLE;
                        busy_r      <= 1'b0;
                        cnt_r       <= {DWELL_W{1'b0}};
                        step_r      <= 1'b0;
`ifdef POS_SCHED_ABORT_EN
                        abort_ack_r <= 1'b1;
`endif
                    end else if (last_step_s) begin
                        ctrl_r <= IDLE;
                        busy_r <= 1'b0;
                        cnt_r  <= {DWELL_W{1'b0}};
                        step_r <= 1'b0;
                        done_r <= 1'b1;
                    end else if (step_r) begin
                        cnt_r  <= {DWELL_W{1'b0}};
                        step_r <= (dwell_r == {DWELL_W{1'b0}});
                    end else begin
                        cnt_r  <= cnt_inc_s;
                        step_r <= (cnt_inc_s == dwell_r);
                    end
                end
                default: begin
                    ctrl_r <= IDLE;
                    busy_r <= 1'b0;
                    step_r <= 1'b0;
                end
            endcase
        end
    end

    pos_walker u_walker (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (step_r),
        .route     (route_r),
        .abort_clr (abort_run_s),
        .state     (walk_state_s),
        .pos       (pos)
    );

    assign gnt        = gnt_r;
    assign owner      = owner_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign step       = step_r;
    assign walk_state = walk_state_s;
`ifdef POS_SCHED_ABORT_EN
    assign abort_ack  = abort_ack_r;
`endif

endmodule

// File: doc/pos_route_sched.md
# pos_route_sched

Schedules the position walker FSM between two requesters. It arbitrates round-robin, latches the winner's route word (the walker decision bits a..g), and paces the walker with a programmable dwell per position. It reports completion when the walker returns to its home state. It sits between the requesting control logic and the 2-bit `pos` actuator output, and it instantiates the walker.

## Interface
- `DWELL_W`, default 4: width of the dwell count.
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `req` input, 2 bits: request per requester. The requester holds it until granted.
- `route0` input, 7 bits: route word from requester 0. Bit 6 is a, down to bit 0, which is g.
- `route1` input, 7 bits: route word from requester 1, same layout.
- `dwell` input, DWELL_W bits: extra cycles per position. Sampled at grant.
- `gnt` output, 2 bits: one-hot, one-cycle grant pulse.
- `owner` output, 1 bit: index of the current or last granted requester.
- `busy` output, 1 bit: high while a pass is running.
- `done` output, 1 bit: one-cycle pulse at the end of a pass.
- `step` output, 1 bit: walker advance strobe.
- `walk_state` output, 4 bits: current walker state, s0..s15.
- `pos` output, 2 bits: walker position.

## Operation
- **Controller states:** IDLE and RUN. Reset enters IDLE.
- **Reset values:** walker in s0, `pos`=00, `gnt`=00, `done`=0, `busy`=0, `step`=0, `owner`=0, latched route=0, dwell counter=0, round-robin pointer favours requester 0.
- **IDLE:**
  - If `req` is nonzero, grant one requester:
    - Only one requester asking: grant it.
    - Both asking: grant the pointer's favourite, then point the pointer at the other requester.
  - On a grant: latch that requester's route and `dwell`, set `owner`, clear the counter, move to RUN.
- **RUN:**
  - The counter increments each cycle.
  - When counter == latched dwell: assert `step`, clear the counter; the walker advances at that edge.
  - `req` is ignored during RUN; no grant is issued.
- **Walker next state** (advances only on `step`; decision bits come from the latched route):
  - s0→s1
  - s1: a ? s2 : s3
  - s2, s3: b ? s4 : s5
  - s4, s5 → s6
  - s6: c ? s8 : s7
  - s7, s8: d ? s9 : s10
  - s9, s10: e ? s11 : (f ? s12 : s13)
  - s11, s12, s13 → s14
  - s14: g ? s15 : s0
  - s15 → s0
- **Walker `pos` decode** (combinational from walker state):
  - 00: s0, s1, s6, s7, s14
  - 11: s10
  - 10: s12
  - 01: all other states
- **End of pass:** a `step` that lands the walker in s0 ends the pass. The controller returns to IDLE.
- **Pass length:** 9 steps, or 10 if g=1.

## Timing
- **Grant:** `gnt[i]` is registered. It is high in the first RUN cycle and lasts exactly one cycle.
- **Step pacing:**
  - The first `step` occurs in RUN cycle D+1, where D is the latched dwell.
  - A pass occupies N·(D+1) RUN cycles, where N is the step count.
  - dwell=0 gives one step per cycle.
- **`busy`:** equals state==RUN.
- **`done`:** registered; high in the first IDLE cycle after the pass.
- **Back-to-back passes:** a grant may be taken in that same IDLE cycle, so the next pass's `gnt` follows `done` by one cycle.
- **Minimum spacing:** between grants is N·(D+1)+1 cycles.
- **Counter:** wraps never; it is cleared at `step` and at grant. dwell = 2^DWELL_W−1 is legal.
- **`rst_n` asserted mid-pass:**
  - Outputs return to reset values immediately (asynchronous).
  - No `done` is generated.
  - The pointer returns to favouring requester 0.

## Configuration
- **`POS_SCHED_ABORT_EN` defined:** adds input `abort` (1 bit) and output `abort_ack` (1 bit).
  - `abort` is sampled in RUN. At that edge the walker goes to s0, the controller goes to IDLE, and the counter clears.
  - `abort_ack` pulses for one cycle; `done` does not pulse.
  - The round-robin pointer is kept.
  - `abort` in IDLE is ignored.
  - If `abort` coincides with a terminal `step`, abort wins.
- **`POS_SCHED_ABORT_EN` undefined:** neither port exists; a pass always runs to s0.

## Structure
- **Shared package `pos_pkg`:**
  - Walker state encoding s0..s15 as 4-bit constants.
  - Position codes 00/01/10/11.
  - Route bit indices A..G.
  - Controller state enum IDLE/RUN.
- **Sub-module `pos_walker`:**
  - Ports: `clk`, `rst_n`, `step`, `route[6:0]`, `abort_clr`, `state[3:0]`, `pos[1:0]`.
  - Holds state when `step`=0.
- **`pos_route_sched`:** holds the arbiter, latches, dwell counter and controller FSM.

## Test plan
- **Single pass, requester 0:** reset, `req`=01, route0=7'b0000000, dwell=0 → `gnt`=01 next cycle; walker visits s1, s3, s5, s6, s7, s10, s13, s14, s0 on 9 consecutive steps; `pos` sequence 00, 01, 01, 00, 00, 11, 01, 00, 00; `done` 1 cycle after the last step.
- **Route with g=1, dwell=3:** route1=7'b1111111, `req`=10 → path s1, s2, s4, s6, s8, s9, s11, s14, s15, s0 (10 steps); `step` every 4th cycle; `busy` high for 40 cycles.
- **Contention:** `req`=11 held continuously, dwell=0 → grants alternate 01, 10, 01; each `gnt` follows the previous `done` by one cycle.
- **Late request:** assert `req[1]` mid-pass of requester 0 → no grant until the pass completes, then `gnt`=10.
- **Reset mid-pass:** drop `rst_n` while walker is in s9 → all outputs reset immediately; `done` never asserted.
- **Abort** (with `POS_SCHED_ABORT_EN`): `abort` in RUN at s6 → `walk_state`=0 next cycle, `abort_ack`=1 for one cycle, `done`=0.
